kbd_keystate: RTL and testbench
===============================

// Module: kbd_keystate
// PURPOSE
//  Consumes the per-key sample stream of the Mk1 keyboard serial link (one strobe per key, 80 keys per
//  frame). Debounces each key and keeps an 80-key state map. Presents keys 0..63 as an 8x8 active-low
//  matrix read by the TMS9901 column scan. Queues debounced press/release events in a FIFO for the
//  host/menu side.
// PARAMETERS
//  DEBOUNCE    2  consecutive differing samples (one per frame) needed to flip a key; legal 1..7
//  FIFO_DEPTH  8  event FIFO entries; power of two, 2..64
// PORTS
//  clk           in   1    system clock
//  reset         in   1    synchronous, active-high reset
//  kbd_scancode  in   7    [0:6] MSB-first key index of current sample (0..79)
//  kbd_keypress  in   1    sample value, 1 = key down
//  kbd_strobe    in   1    1-cycle pulse: scancode/keypress valid
//  col_sel       in   3    [0:2] matrix column selected by TMS9901
//  row_n         out  8    [0:7] rows of selected column, 0 = key down, registered
//  ev_valid      out  1    FIFO head valid
//  ev_scancode   out  7    [0:6] head event key index
//  ev_press      out  1    head event: 1 = press, 0 = release
//  ev_ready      in   1    consumer pops head when ev_valid & ev_ready
//  ev_overflow   out  1    sticky: an event was dropped
//  ev_ovf_clr    in   1    clears ev_overflow
// BEHAVIOUR
//  - Reset (synchronous, active-high): all key states released, all debounce counters 0, FIFO empty.
//    Outputs: row_n=8'hFF, ev_valid=0, ev_overflow=0. ev_scancode/ev_press = 0.
//  - Per-key storage: state bit + 3-bit counter, indexed by scancode.
//  - Sample handling:
//    - Strobes with scancode>=80 are ignored.
//    - On a valid strobe: if keypress==state[k], counter[k]<=0.
//    - Otherwise counter[k]+1 is computed. If it equals DEBOUNCE, state[k] flips, counter[k]<=0 and an
//      event {k, new state} is pushed. Else counter[k] increments.
//    - A single opposite sample between two agreeing samples resets the count (no glitch passes).
//  - Timing: state update and FIFO push both land the cycle after the strobe.
//    Strobes are >=2 cycles apart; back-to-back strobes need not be supported.
//  - Matrix mapping:
//    - For k<64: column=k[1:3], row=k[4:6]. Keys 64..79 appear only as events.
//    - row_n[r] <= ~state[{col_sel,r}] every cycle, 1-cycle latency from col_sel or state change.
//  - FIFO:
//    - First-word-fall-through. ev_* are valid whenever ev_valid=1 and stay stable until popped.
//    - Push when full with no pop: event dropped, ev_overflow<=1.
//    - Push and pop in the same cycle when full: both accepted, count unchanged, no overflow.
//    - Pop when empty: ignored.
//    - Pointers wrap modulo FIFO_DEPTH.
//  - Overflow flag:
//    - ev_ovf_clr clears ev_overflow.
//    - Same-cycle drop and clear: flag stays 1 (set wins).
//  - Reset during a frame: takes effect immediately.
//    - Keys still held re-report a press after DEBOUNCE further samples.
//    - No release events are generated for keys cleared by reset.
// TESTING
//  1. Reset, DEBOUNCE=2, drive key 0x1B down for 2 frames.
//     -> after 2nd strobe: one event {0x1B,1}; col_sel=3 gives row_n=8'b11110111.
//  2. Key 0x1B alternates down/up/down/up each frame.
//     -> no event ever; row_n stays 8'hFF.
//  3. Key 0x45 pressed 2 frames, released 2 frames.
//     -> events {0x45,1} then {0x45,0}; row_n unaffected for every col_sel.
//  4. ev_ready=0; generate 9 distinct press events with FIFO_DEPTH=8.
//     -> 8 entries held in order, 9th dropped, ev_overflow=1; ev_ovf_clr pulse -> ev_overflow=0.
//  5. FIFO full; next push coincides with pop (ev_ready=1).
//     -> head advances, new event at tail, ev_overflow stays 0.
//  6. Hold key 0x00 pressed; assert reset mid-frame.
//     -> row_n=8'hFF, ev_valid=0 next cycle; {0x00,1} re-emitted after 2 further samples.
//  7. Strobe with scancode=0x50..0x7F (80..127).
//     -> no state change, no event.

Source files
------------

// File: rtl/kbd_keystate.sv
// Keyboard key-state tracker: per-key debounce, 8x8 active-low matrix view
// for the column scanner, and a press/release event FIFO for the host side.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   kbd_scancode[6:0] key index of the current sample (0..79 valid)
//   kbd_keypress      sample value, 1 = key down
//   kbd_strobe        1-cycle pulse qualifying scancode/keypress
//   col_sel[2:0]      matrix column selected by the scanner
//   row_n[7:0]        registered rows of the selected column, 0 = down
//   ev_valid          event FIFO head valid
//   ev_scancode[6:0]  head event key index
//   ev_press          head event: 1 = press, 0 = release
//   ev_ready          pops the head when ev_valid is high
//   ev_overflow       sticky flag: an event was dropped
//   ev_ovf_clr        clears ev_overflow
module kbd_keystate #(
  parameter int DEBOUNCE   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] kbd_scancode,
  input  logic       kbd_keypress,
  input  logic       kbd_strobe,
  input  logic [2:0] col_sel,
  output logic [7:0] row_n,
  output logic       ev_valid,
  output logic [6:0] ev_scancode,
  output logic       ev_press,
  input  logic       ev_ready,
  output logic       ev_overflow,
  input  logic       ev_ovf_clr
);

  localparam int          NKEYS = 80;
  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [2:0]  DB    = 3'(DEBOUNCE);
  localparam logic [AW:0] FULL  = (AW+1)'(FIFO_DEPTH);

  logic [NKEYS-1:0] r_state;
  logic [2:0]       r_cnt [NKEYS];

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             r_ovf;
  logic [7:0]       r_row_n;

  logic       w_kvalid;
  logic [6:0] w_idx;
  logic       w_diff;
  logic [2:0] w_inc;
  logic       w_flip;
  logic       w_pop;
  logic       w_full;
  logic       w_push;
  logic [7:0] w_row;

  // Out-of-range scancodes are steered to key 0 but never written back.
  assign w_kvalid = kbd_strobe && (kbd_scancode < 7'(NKEYS));
  assign w_idx    = w_kvalid ? kbd_scancode : 7'd0;
  assign w_diff   = kbd_keypress != r_state[w_idx];
  assign w_inc    = r_cnt[w_idx] + 3'd1;
  assign w_flip   = w_kvalid && w_diff && (w_inc == DB);

  assign ev_valid = r_count != '0;
  assign w_full   = r_count == FULL;
  assign w_pop    = ev_valid && ev_ready;
  // A full FIFO still accepts a push when the head leaves the same cycle.
  assign w_push   = w_flip && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
      for (int i = 0; i < NKEYS; i++)
        r_cnt[i] <= 3'd0;
    end else if (w_kvalid) begin
      if (!w_diff || w_flip)
        r_cnt[w_idx] <= 3'd0;
      else
        r_cnt[w_idx] <= w_inc;
      if (w_flip)
        r_state[w_idx] <= kbd_keypress;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr] <= {w_idx, kbd_keypress};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + 1'b1;
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset)
      r_ovf <= 1'b0;
    else if (w_flip && !w_push)
      r_ovf <= 1'b1;
    else if (ev_ovf_clr)
      r_ovf <= 1'b0;
  end

  always_comb begin
    w_row = '1;
    for (int r = 0; r < 8; r++)
      w_row[r] = ~r_state[{1'b0, col_sel, 3'(r)}];
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_row_n <= 8'hFF;
    else
      r_row_n <= w_row;
  end

  assign row_n       = r_row_n;
  assign ev_overflow = r_ovf;
  assign ev_scancode = ev_valid ? r_mem[r_rd][7:1] : 7'd0;
  assign ev_press    = ev_valid ? r_mem[r_rd][0]   : 1'b0;

endmodule

// File: tb/tb_kbd_keystate.sv
// Directed bench for kbd_keystate: debounce, matrix view, event FIFO,
// overflow flag, mid-stream reset and out-of-range scancodes.
module tb_kbd_keystate;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] kbd_scancode;
  logic       kbd_keypress;
  logic       kbd_strobe;
  logic [2:0] col_sel;
  logic [7:0] row_n;
  logic       ev_valid;
  logic [6:0] ev_scancode;
  logic       ev_press;
  logic       ev_ready;
  logic       ev_overflow;
  logic       ev_ovf_clr;

  int n_chk = 0;
  int n_err = 0;

  kbd_keystate #(.DEBOUNCE(2), .FIFO_DEPTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .kbd_scancode(kbd_scancode),
    .kbd_keypress(kbd_keypress),
    .kbd_strobe(kbd_strobe),
    .col_sel(col_sel),
    .row_n(row_n),
    .ev_valid(ev_valid),
    .ev_scancode(ev_scancode),
    .ev_press(ev_press),
    .ev_ready(ev_ready),
    .ev_overflow(ev_overflow),
    .ev_ovf_clr(ev_ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge two cycles later so both
  // the event and the registered row_n reflect the sample.
  task automatic strobe(input logic [6:0] code, input logic dn);
    kbd_scancode = code;
    kbd_keypress = dn;
    kbd_strobe   = 1'b1;
    @(negedge clk);
    kbd_strobe   = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop();
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  task automatic chk_ev(input string tag,
                        input logic [6:0] code,
                        input logic dn);
    chk({tag, "_v"}, 32'(ev_valid), 32'd1);
    chk({tag, "_k"}, 32'(ev_scancode), 32'(code));
    chk({tag, "_p"}, 32'(ev_press), 32'(dn));
  endtask

  initial begin
    reset        = 1'b1;
    kbd_scancode = '0;
    kbd_keypress = 1'b0;
    kbd_strobe   = 1'b0;
    col_sel      = 3'd3;
    ev_ready     = 1'b0;
    ev_ovf_clr   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_row", 32'(row_n), 32'hFF);
    chk("rst_val", 32'(ev_valid), 32'd0);
    chk("rst_ovf", 32'(ev_overflow), 32'd0);
    chk("rst_key", 32'(ev_scancode), 32'd0);
    chk("rst_prs", 32'(ev_press), 32'd0);

    // key 0x1B: column 3, row 3
    strobe(7'h1B, 1'b1);
    chk("t1_nev", 32'(ev_valid), 32'd0);
    chk("t1_row0", 32'(row_n), 32'hFF);
    strobe(7'h1B, 1'b1);
    chk_ev("t1_ev", 7'h1B, 1'b1);
    chk("t1_row", 32'(row_n), 32'hF7);
    pop();
    chk("t1_pop", 32'(ev_valid), 32'd0);

    // release, then alternate without ever reaching the debounce count
    strobe(7'h1B, 1'b0);
    strobe(7'h1B, 1'b0);
    chk_ev("t2_rel", 7'h1B, 1'b0);
    pop();
    for (int i = 0; i < 4; i++) begin
      strobe(7'h1B, (i % 2) == 0);
      chk("t2_nev", 32'(ev_valid), 32'd0);
      chk("t2_row", 32'(row_n), 32'hFF);
    end

    // key 0x45 lives outside the matrix
    strobe(7'h45, 1'b1);
    strobe(7'h45, 1'b1);
    chk_ev("t3_prs", 7'h45, 1'b1);
    for (int c = 0; c < 8; c++) begin
      col_sel = 3'(c);
      @(negedge clk);
      chk("t3_row", 32'(row_n), 32'hFF);
    end
    pop();
    strobe(7'h45, 1'b0);
    strobe(7'h45, 1'b0);
    chk_ev("t3_rel", 7'h45, 1'b0);
    pop();
    chk("t3_emp", 32'(ev_valid), 32'd0);

    // nine presses into an 8-deep FIFO: 0x18 is dropped
    for (int k = 0; k < 9; k++) begin
      strobe(7'(8'h10 + k), 1'b1);
      strobe(7'(8'h10 + k), 1'b1);
    end
    chk("t4_ovf", 32'(ev_overflow), 32'd1);
    chk_ev("t4_head", 7'h10, 1'b1);
    ev_ovf_clr = 1'b1;
    @(negedge clk);
    ev_ovf_clr = 1'b0;
    chk("t4_clr", 32'(ev_overflow), 32'd0);

    // push into a full FIFO coinciding with a pop
    strobe(7'h19, 1'b1);
    kbd_scancode = 7'h19;
    kbd_keypress = 1'b1;
    kbd_strobe   = 1'b1;
    ev_ready     = 1'b1;
    @(negedge clk);
    kbd_strobe   = 1'b0;
    ev_ready     = 1'b0;
    chk("t5_ovf", 32'(ev_overflow), 32'd0);
    chk_ev("t5_head", 7'h11, 1'b1);
    for (int k = 1; k < 8; k++) begin
      chk_ev("t5_ord", 7'(8'h10 + k), 1'b1);
      pop();
    end
    chk_ev("t5_tail", 7'h19, 1'b1);
    pop();
    chk("t5_emp", 32'(ev_valid), 32'd0);
    pop();
    chk("t5_epop", 32'(ev_valid), 32'd0);

    // key 0x00 held across a reset
    col_sel = 3'd0;
    strobe(7'h00, 1'b1);
    strobe(7'h00, 1'b1);
    chk_ev("t6_ev", 7'h00, 1'b1);
    chk("t6_row", 32'(row_n), 32'hFE);
    strobe(7'h00, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_rrow", 32'(row_n), 32'hFF);
    chk("t6_rval", 32'(ev_valid), 32'd0);
    strobe(7'h00, 1'b1);
    chk("t6_nev", 32'(ev_valid), 32'd0);
    strobe(7'h00, 1'b1);
    chk_ev("t6_re", 7'h00, 1'b1);
    chk("t6_row2", 32'(row_n), 32'hFE);
    pop();

    // out-of-range scancodes are ignored
    for (int i = 0; i < 2; i++) begin
      strobe(7'h50, 1'b1);
      strobe(7'h7F, 1'b1);
    end
    chk("t7_nev", 32'(ev_valid), 32'd0);
    chk("t7_row", 32'(row_n), 32'hFE);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
